// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for the 2-input gates block: sweeps all four (a,b) vectors,
// checks the seven gate outputs and reports pass/err_cnt/fail_mask. Optional GATE_SWEEP_LOOP_EN adds loop_en soak mode.
module gate_sweep_ctrl #(
  parameter int HOLD_CYC = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
`ifdef GATE_SWEEP_LOOP_EN
  input  logic             loop_en,
`endif
  input  logic [6:0]       gate_y,
  output logic             gate_a,
  output logic             gate_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [6:0]       fail_mask
);

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Truth table of {INV,XNOR,XOR,NAND,NOR,OR,AND} for each {a,b} vector.
  function automatic logic [6:0] exp_y(input logic [1:0] v);
    logic [6:0] y;
    case (v)
      2'd0:    y = 7'h6C;
      2'd1:    y = 7'h5A;
      2'd2:    y = 7'h1A;
      2'd3:    y = 7'h23;
      default: y = 7'h23;
    endcase
    return y;
  endfunction

  state_t              state_r;
  logic [1:0]          vec_r;
  logic [HOLD_W-1:0]   hold_cnt_r;
  logic                gate_a_r;
  logic                gate_b_r;
  logic                busy_r;
  logic                done_r;
  logic                pass_r;
  logic [CNT_W-1:0]    err_cnt_r;
  logic [6:0]          fail_mask_r;

  logic [6:0]          diff_s;
  logic [1:0]          vec_nxt_s;
  logic                loop_s;

  assign diff_s    = gate_y ^ exp_y(vec_r);
  assign vec_nxt_s = vec_r + 2'd1;
`ifdef GATE_SWEEP_LOOP_EN
  assign loop_s    = loop_en;
`else
  assign loop_s    = 1'b0;
`endif

  // Sweep sequencer with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      vec_r       <= 2'd0;
      hold_cnt_r  <= {HOLD_W{1'b0}};
      gate_a_r    <= 1'b0;
      gate_b_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_cnt_r   <= {CNT_W{1'b0}};
      fail_mask_r <= 7'h00;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && !abort) begin
            state_r     <= ST_DRIVE;
            vec_r       <= 2'd0;
            hold_cnt_r  <= {HOLD_W{1'b0}};
            gate_a_r    <= 1'b0;
            gate_b_r    <= 1'b0;
            busy_r      <= 1'b1;
            pass_r      <= 1'b0;
            err_cnt_r   <= {CNT_W{1'b0}};
            fail_mask_r <= 7'h00;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DRIVE: begin
          if (abort) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            pass_r   <= 1'b0;
            gate_a_r <= 1'b0;
            gate_b_r <= 1'b0;
          end else if (hold_cnt_r == HOLD_W'(HOLD_CYC - 1)) begin
            state_r    <= ST_CHECK;
            hold_cnt_r <= {HOLD_W{1'b0}};
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        ST_CHECK: begin
          if (abort) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            pass_r   <= 1'b0;
            gate_a_r <= 1'b0;
            gate_b_r <= 1'b0;
          end else begin
            // err_cnt saturates; fail_mask accumulates only the bits that disagree.
            if (|diff_s) begin
              if (err_cnt_r != {CNT_W{1'b1}}) begin
                err_cnt_r <= err_cnt_r + CNT_W'(1);
              end else begin
                err_cnt_r <= err_cnt_r;
              end
              fail_mask_r <= fail_mask_r | diff_s;
            end else begin
              fail_mask_r <= fail_mask_r;
            end
            if (vec_r == 2'd3) begin
              state_r <= ST_FIN;
            end else begin
              state_r  <= ST_DRIVE;
              vec_r    <= vec_nxt_s;
              gate_a_r <= vec_nxt_s[1];
              gate_b_r <= vec_nxt_s[0];
            end
          end
        end
        ST_FIN: begin
          gate_a_r <= 1'b0;
          gate_b_r <= 1'b0;
          vec_r    <= 2'd0;
          if (abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            pass_r  <= 1'b0;
          end else begin
            done_r <= 1'b1;
            pass_r <= (err_cnt_r == {CNT_W{1'b0}});
            if (loop_s) begin
              state_r    <= ST_DRIVE;
              hold_cnt_r <= {HOLD_W{1'b0}};
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          busy_r   <= 1'b0;
          gate_a_r <= 1'b0;
          gate_b_r <= 1'b0;
        end
      endcase
    end
  end

  assign gate_a    = gate_a_r;
  assign gate_b    = gate_b_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_cnt   = err_cnt_r;
  assign fail_mask = fail_mask_r;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl with a behavioural gates model whose outputs can be stuck at 0.
module tb_gate_sweep_ctrl;

`ifdef GATE_SWEEP_LOOP_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic             loop_en;
  logic [6:0]       gate_y;
  logic [6:0]       zero_mask;
  logic             gate_a;
  logic             gate_b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [6:0]       fail_mask;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Fault-free gates, with selected outputs forced low.
  always_comb begin
    gate_y = {~gate_a, ~(gate_a ^ gate_b), gate_a ^ gate_b, ~(gate_a & gate_b),
              ~(gate_a | gate_b), gate_a | gate_b, gate_a & gate_b} & ~zero_mask;
  end

  gate_sweep_ctrl #(.HOLD_CYC(4), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (rst),
    .start     (start),
    .abort     (abort),
`ifdef GATE_SWEEP_LOOP_EN
    .loop_en   (loop_en),
`endif
    .gate_y    (gate_y),
    .gate_a    (gate_a),
    .gate_b    (gate_b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_mask (fail_mask)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_ab(input int e);
    int v;
    v = e / 5;
    if (e >= 21) v = 0;
    else if (v > 3) v = 3;
    return 2'(v);
  endfunction

  // One full sweep from a start pulse, checking a/b, busy and done after every edge.
  task automatic run_sweep(input logic [6:0] zm, input int glitch_at,
                           input logic [31:0] exp_err, input logic [6:0] exp_mask,
                           input logic exp_pass);
    zero_mask = zm;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_eq("busy_e0", 32'(busy), 32'd1);
    chk_eq("ab_e0", 32'({gate_a, gate_b}), 32'd0);
    chk_eq("err_clr", 32'(err_cnt), 32'd0);
    chk_eq("mask_clr", 32'(fail_mask), 32'd0);
    chk_eq("pass_clr", 32'(pass), 32'd0);
    for (int e = 1; e <= 21; e++) begin
      start = (e == glitch_at) ? 1'b1 : 1'b0;
      step();
      start = 1'b0;
      chk_eq("ab", 32'({gate_a, gate_b}), 32'(exp_ab(e)));
      chk_eq("busy", 32'(busy), (e < 21) ? 32'd1 : 32'd0);
      chk_eq("done", 32'(done), (e == 21) ? 32'd1 : 32'd0);
    end
    chk_eq("pass", 32'(pass), 32'(exp_pass));
    chk_eq("err_cnt", 32'(err_cnt), exp_err);
    chk_eq("fail_mask", 32'(fail_mask), 32'(exp_mask));
    step();
    chk_eq("done_1cyc", 32'(done), 32'd0);
    chk_eq("pass_hold", 32'(pass), 32'(exp_pass));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0; zero_mask = 7'h00;
    step();
    chk_eq("rst_outs", 32'({gate_a, gate_b, busy, done, pass}), 32'd0);
    chk_eq("rst_err", 32'(err_cnt), 32'd0);
    chk_eq("rst_mask", 32'(fail_mask), 32'd0);
    rst = 1'b0;
    repeat (3) step();
    chk_eq("idle_outs", 32'({gate_a, gate_b, busy, done, pass}), 32'd0);

    run_sweep(7'h00, 0, 32'd0, 7'h00, 1'b1);
    run_sweep(7'h10, 0, 32'd2, 7'h10, 1'b0);
    run_sweep(7'h00, 3, 32'd0, 7'h00, 1'b1);

    // abort at edge 7 of a faulted sweep
    zero_mask = 7'h10;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_eq("abort_busy", 32'(busy), 32'd0);
    chk_eq("abort_ab", 32'({gate_a, gate_b}), 32'd0);
    chk_eq("abort_pass", 32'(pass), 32'd0);
    chk_eq("abort_err", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk_eq("abort_nodone", 32'({busy, done}), 32'd0);
    end
    run_sweep(7'h00, 0, 32'd0, 7'h00, 1'b1);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk_eq("sa_busy", 32'(busy), 32'd0);
    step();
    chk_eq("sa_busy2", 32'({busy, gate_a, gate_b}), 32'd0);
    chk_eq("sa_pass", 32'(pass), 32'd1);

    // asynchronous reset mid-sweep, between edges 12 and 13
    zero_mask = 7'h10;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    chk_eq("pre_rst_err", 32'(err_cnt), 32'd1);
    chk_eq("pre_rst_ab", 32'({gate_a, gate_b}), 32'd2);
    chk_eq("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_eq("async_outs", 32'({gate_a, gate_b, busy, done, pass}), 32'd0);
    chk_eq("async_err", 32'(err_cnt), 32'd0);
    chk_eq("async_mask", 32'(fail_mask), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk_eq("post_rst_busy", 32'(busy), 32'd0);
    run_sweep(7'h00, 0, 32'd0, 7'h00, 1'b1);

`ifdef GATE_SWEEP_LOOP_EN
    // two-loop soak with INV stuck low: two mismatches per loop, saturating at 3
    zero_mask = 7'h40;
    loop_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 42; e++) begin
      loop_en = (e < 30) ? 1'b1 : 1'b0;
      step();
      chk_eq("lp_ab", 32'({gate_a, gate_b}), 32'(exp_ab((e < 21) ? e : e - 21)));
      chk_eq("lp_busy", 32'(busy), (e < 42) ? 32'd1 : 32'd0);
      chk_eq("lp_done", 32'(done), (e == 21 || e == 42) ? 32'd1 : 32'd0);
      if (e == 21) chk_eq("lp1_err", 32'(err_cnt), 32'd2);
      if (e == 26) chk_eq("lp2_sat", 32'(err_cnt), 32'd3);
    end
    chk_eq("lp_err", 32'(err_cnt), 32'd3);
    chk_eq("lp_mask", 32'(fail_mask), 32'h40);
    chk_eq("lp_pass", 32'(pass), 32'd0);
    loop_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
